// File: rtl/smart_bextdep_unit.sv
// -----------------------------------------------------------------------------
// smart_bextdep_unit
//
// Bit-extract (bext) / bit-deposit (bdep) unit for the bitmanip execute stage.
// One operation is accepted every clock; the result is registered and appears
// one cycle after its operands were sampled.
//
//   bext: the rs1 bits at the set positions of the rs2 mask are packed, in
//         order, into the LSBs of rd. The upper bits of rd are zero.
//   bdep: the LSBs of rs1 are scattered, in order, into the set positions of
//         the rs2 mask. All other bits of rd are zero.
//
// Ports
//   clock  in   1   rising-edge clock
//   reset  in   1   synchronous, active-high reset (clears rd)
//   bdep   in   1   operation select: 0 = bext, 1 = bdep
//   rs1    in  32   data operand
//   rs2    in  32   mask operand
//   rd     out 32   registered result
//
// Structure
//   Each selected bit at position i must move right by z(i), the number of
//   mask zeros below i. A five-stage compress network applies that shift one
//   binary digit at a time, LSB first (distances 1, 2, 4, 8, 16). Each bit
//   carries its own shift amount through the network, so the network never
//   needs recomputed per-stage controls. Running the same shifts in reverse
//   order (16 down to 1, moving left) is the exact inverse, which gives
//   deposit. The control for deposit (the shift amount per source bit) is
//   simply the z values after compression, which depend only on the mask.
// -----------------------------------------------------------------------------
module smart_bextdep_unit (
    input  logic        clock,
    input  logic        reset,
    input  logic        bdep,
    input  logic [31:0] rs1,
    input  logic [31:0] rs2,
    output logic [31:0] rd
);

    // Prefix zero counts of the mask
    logic [5:0]  zacc_s;
    logic [4:0]  zpre_s [0:31];

    // Compress network state per stage: valid, data, remaining shift amount
    logic [31:0] cv_s [0:5];
    logic [31:0] cd_s [0:5];
    logic [4:0]  cz_s [0:5][0:31];

    // Expand network state per stage
    logic [31:0] ev_s [0:5];
    logic [31:0] ed_s [0:5];
    logic [4:0]  ez_s [0:5][0:31];

    logic [31:0] ext_s;
    logic [31:0] dep_s;
    logic [31:0] rd_d;
    logic [31:0] rd_q;

    // Mask control: z(i) = number of zero mask bits strictly below bit i
    always_comb begin
        zacc_s = 6'd0;
        for (int i = 0; i < 32; i++) begin
            zpre_s[i] = zacc_s[4:0];
            zacc_s    = zacc_s + {5'd0, ~rs2[i]};
        end
    end

    // Compress (extract) network, shift distances 1, 2, 4, 8, 16.
    // Bit order is preserved at every stage, so a destination never receives
    // both a staying bit and an arriving bit.
    always_comb begin
        cv_s[0] = rs2;
        cd_s[0] = rs1 & rs2;
        for (int k = 0; k < 32; k++) begin
            cz_s[0][k] = zpre_s[k];
        end
        for (int s = 0; s < 5; s++) begin
            cv_s[s+1] = 32'd0;
            cd_s[s+1] = 32'd0;
            for (int k = 0; k < 32; k++) begin
                cz_s[s+1][k] = 5'd0;
            end
            for (int k = 0; k < 32; k++) begin
                int src;
                src = (k + (1 << s)) & 31;
                if (cv_s[s][k] && !cz_s[s][k][s]) begin
                    cv_s[s+1][k] = 1'b1;
                    cd_s[s+1][k] = cd_s[s][k];
                    cz_s[s+1][k] = cz_s[s][k];
                end else if ((k + (1 << s)) < 32 && cv_s[s][src] && cz_s[s][src][s]) begin
                    cv_s[s+1][k] = 1'b1;
                    cd_s[s+1][k] = cd_s[s][src];
                    cz_s[s+1][k] = cz_s[s][src];
                end else begin
                    cv_s[s+1][k] = 1'b0;
                end
            end
        end
        ext_s = cd_s[5];
    end

    // Expand (deposit) network: the compress stages undone in reverse order.
    // Source bit j (j < popcount) carries z(p_j), taken from the compressed
    // control, and moves left by that amount.
    always_comb begin
        ev_s[0] = cv_s[5];
        ed_s[0] = rs1 & cv_s[5];
        for (int k = 0; k < 32; k++) begin
            ez_s[0][k] = cz_s[5][k];
        end
        for (int t = 0; t < 5; t++) begin
            int s;
            s = 4 - t;
            ev_s[t+1] = 32'd0;
            ed_s[t+1] = 32'd0;
            for (int k = 0; k < 32; k++) begin
                ez_s[t+1][k] = 5'd0;
            end
            for (int k = 0; k < 32; k++) begin
                int src;
                src = (k - (1 << s)) & 31;
                if (ev_s[t][k] && !ez_s[t][k][s]) begin
                    ev_s[t+1][k] = 1'b1;
                    ed_s[t+1][k] = ed_s[t][k];
                    ez_s[t+1][k] = ez_s[t][k];
                end else if (k >= (1 << s) && ev_s[t][src] && ez_s[t][src][s]) begin
                    ev_s[t+1][k] = 1'b1;
                    ed_s[t+1][k] = ed_s[t][src];
                    ez_s[t+1][k] = ez_s[t][src];
                end else begin
                    ev_s[t+1][k] = 1'b0;
                end
            end
        end
        // Mask applied after deposit so unselected positions always read 0
        dep_s = ed_s[5] & rs2;
    end

    // Operation select
    always_comb begin
        if (bdep) begin
            rd_d = dep_s;
        end else begin
            rd_d = ext_s;
        end
    end

    // Result register with synchronous reset
    always_ff @(posedge clock) begin
        if (reset) begin
            rd_q <= 32'd0;
        end else begin
            rd_q <= rd_d;
        end
    end

    assign rd = rd_q;

endmodule

// File: tb/tb_smart_bextdep_unit.sv
module tb_smart_bextdep_unit;

    logic        clock;
    logic        reset;
    logic        bdep;
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic [31:0] rd;

    int          n_tests;
    int          n_fail;
    logic [31:0] last_exp;

    smart_bextdep_unit dut (
        .clock (clock),
        .reset (reset),
        .bdep  (bdep),
        .rs1   (rs1),
        .rs2   (rs2),
        .rd    (rd)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Reference: walk the mask bit by bit, keeping a running output index
    function automatic logic [31:0] ref_bext(input logic [31:0] x, input logic [31:0] m);
        logic [31:0] r;
        int j;
        r = 32'd0;
        j = 0;
        for (int i = 0; i < 32; i++) begin
            if (m[i]) begin
                r[j] = x[i];
                j++;
            end
        end
        return r;
    endfunction

    function automatic logic [31:0] ref_bdep(input logic [31:0] x, input logic [31:0] m);
        logic [31:0] r;
        int j;
        r = 32'd0;
        j = 0;
        for (int i = 0; i < 32; i++) begin
            if (m[i]) begin
                r[i] = x[j];
                j++;
            end
        end
        return r;
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: rd=0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Drive one operation on the falling edge, confirm rd still shows the
    // previous result (no combinational path), then check the new result
    // just after the rising edge.
    task automatic run_op(input string tag, input logic m, input logic [31:0] a,
                          input logic [31:0] b);
        @(negedge clock);
        reset = 1'b0;
        bdep  = m;
        rs1   = a;
        rs2   = b;
        #1;
        check_eq({tag, "_hold"}, rd, last_exp);
        @(posedge clock);
        #1;
        last_exp = m ? ref_bdep(a, b) : ref_bext(a, b);
        check_eq(tag, rd, last_exp);
    endtask

    // Hold reset for n edges while random operands keep arriving
    task automatic reset_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clock);
            reset = 1'b1;
            bdep  = 1'($urandom);
            rs1   = $urandom;
            rs2   = $urandom;
            @(posedge clock);
            #1;
            check_eq("reset_clear", rd, 32'd0);
        end
        last_exp = 32'd0;
    endtask

    initial begin
        logic [31:0] a;
        logic [31:0] m;
        logic [31:0] packed_v;
        logic [31:0] mask_n;
        n_tests  = 0;
        n_fail   = 0;
        last_exp = 32'd0;
        reset    = 1'b1;
        bdep     = 1'b0;
        rs1      = 32'hFFFF_FFFF;
        rs2      = 32'hFFFF_FFFF;

        reset_cycles(2);

        // Directed vectors from the plan
        run_op("bext_basic0", 1'b0, 32'h1234_5678, 32'h0000_FF00);
        check_eq("bext_basic0_const", rd, 32'h0000_0056);
        run_op("bext_basic1", 1'b0, 32'hFFFF_FFFF, 32'h8000_0001);
        check_eq("bext_basic1_const", rd, 32'h0000_0003);
        run_op("bdep_basic0", 1'b1, 32'h0000_00AB, 32'h0F0F_0000);
        check_eq("bdep_basic0_const", rd, 32'h0A0B_0000);
        run_op("bdep_basic1", 1'b1, 32'hFFFF_FFFF, 32'hAAAA_AAAA);
        check_eq("bdep_basic1_const", rd, 32'hAAAA_AAAA);

        // Mask extremes, both modes
        run_op("bext_mask0", 1'b0, 32'hDEAD_BEEF, 32'h0000_0000);
        check_eq("bext_mask0_const", rd, 32'h0000_0000);
        run_op("bdep_mask0", 1'b1, 32'hDEAD_BEEF, 32'h0000_0000);
        check_eq("bdep_mask0_const", rd, 32'h0000_0000);
        run_op("bext_maskF", 1'b0, 32'hDEAD_BEEF, 32'hFFFF_FFFF);
        check_eq("bext_maskF_const", rd, 32'hDEAD_BEEF);
        run_op("bdep_maskF", 1'b1, 32'hDEAD_BEEF, 32'hFFFF_FFFF);
        check_eq("bdep_maskF_const", rd, 32'hDEAD_BEEF);

        // Low-contiguous masks 2^n-1: result is rs1 & mask in both modes
        for (int n = 0; n <= 32; n++) begin
            mask_n = (n == 32) ? 32'hFFFF_FFFF : ((32'd1 << n) - 32'd1);
            a = $urandom;
            run_op("bext_lowmask", 1'b0, a, mask_n);
            check_eq("bext_lowmask_and", rd, a & mask_n);
            a = $urandom;
            run_op("bdep_lowmask", 1'b1, a, mask_n);
            check_eq("bdep_lowmask_and", rd, a & mask_n);
        end

        // Streaming: 1000 bext, then 1000 bdep, back to back
        for (int i = 0; i < 1000; i++) begin
            run_op("stream_bext", 1'b0, $urandom, $urandom);
        end
        for (int i = 0; i < 1000; i++) begin
            run_op("stream_bdep", 1'b1, $urandom, $urandom);
        end

        // Mixed stream with sparse/dense masks and a reset in the middle
        for (int i = 0; i < 400; i++) begin
            m = $urandom;
            case (i % 4)
                0:       m = m & $urandom;
                1:       m = m | $urandom;
                default: m = m;
            endcase
            run_op("stream_mixed", 1'($urandom), $urandom, m);
            if (i == 200) begin
                reset_cycles(2);
            end
        end

        // First result after release appears one edge after release
        reset_cycles(2);
        run_op("post_reset_first", 1'b0, 32'h1234_5678, 32'h0000_FF00);
        check_eq("post_reset_first_const", rd, 32'h0000_0056);

        // Round trip through the DUT: bdep(bext(x, m), m) == x & m
        for (int i = 0; i < 100; i++) begin
            a = $urandom;
            m = $urandom;
            run_op("rt_bext", 1'b0, a, m);
            packed_v = rd;
            run_op("rt_bdep", 1'b1, packed_v, m);
            check_eq("round_trip", rd, a & m);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    // Global watchdog so the run always ends
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
